// File: rtl/stencil_2d_invoker.sv
// stencil_2d_invoker: issues a run of stencil_2d calls with a bounded number
// in flight, buffers the returned words in a small FIFO towards a downstream
// consumer, and keeps a per-run XOR checksum and active-cycle count.
`timescale 1ns/1ps
module stencil_2d_invoker #(
    parameter int MAX_OUT    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run_start,
    input  logic [15:0] run_count,
    output logic        run_busy,
    output logic        run_done,
    output logic        comp_start,
    input  logic        comp_busy,
    input  logic        comp_done,
    output logic        comp_stall,
    input  logic [31:0] comp_returndata,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [31:0] checksum,
    output logic [31:0] cycles,
    output logic        err_unexpected
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] count;
    logic [15:0] issued;
    logic [15:0] returned;
    logic [15:0] outstanding;

    logic [31:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;

    logic fifo_full;
    logic fifo_empty;
    logic start_fire;
    logic call_req;
    logic call_fire;
    logic ret_fire;
    logic push;
    logic pop;
    logic active;

    assign outstanding = issued - returned;
    assign fifo_full   = (occ == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty  = (occ == '0);
    assign active      = (state == ISSUE) || (state == DRAIN);
    assign start_fire  = (state == IDLE) && run_start;
    assign call_req    = (state == ISSUE) && (issued < count) && (outstanding < 16'(MAX_OUT));
    assign call_fire   = call_req && !comp_busy;
    // stall comes from registered occupancy only, so a pop never frees a slot
    // for a return in the same cycle
    assign ret_fire    = comp_done && !fifo_full;
    assign push        = ret_fire && (outstanding != '0);
    assign pop         = !fifo_empty && res_ready;

    // outputs are forced low while reset is held, even before the first edge
    assign run_busy   = active && !reset;
    assign run_done   = (state == FIN) && !reset;
    assign comp_start = call_req && !reset;
    assign comp_stall = fifo_full && !reset;
    assign res_valid  = !fifo_empty && !reset;
    assign res_data   = (reset || fifo_empty) ? '0 : mem[rd_ptr];

    // state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state selection
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (run_start) begin
                    state_next = (run_count == '0) ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                if (issued == count) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((returned == count) && fifo_empty) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // run counters, checksum, active-cycle count and unexpected-return flag
    always_ff @(posedge clock) begin
        if (reset) begin
            count          <= '0;
            issued         <= '0;
            returned       <= '0;
            checksum       <= '0;
            cycles         <= '0;
            err_unexpected <= 1'b0;
        end else if (start_fire) begin
            count          <= run_count;
            issued         <= '0;
            returned       <= '0;
            checksum       <= '0;
            cycles         <= '0;
            err_unexpected <= 1'b0;
        end else begin
            if (call_fire) begin
                issued <= issued + 16'd1;
            end
            if (ret_fire) begin
                if (outstanding != '0) begin
                    returned <= returned + 16'd1;
                    checksum <= checksum ^ comp_returndata;
                end else begin
                    err_unexpected <= 1'b1;
                end
            end
            if (active && (cycles != '1)) begin
                cycles <= cycles + 32'd1;
            end
        end
    end

    // result FIFO pointers and occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // result FIFO storage
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= comp_returndata;
        end
    end

endmodule

// File: tb/tb_stencil_2d_invoker.sv
// tb_stencil_2d_invoker: directed runs against a behavioural stencil_2d model;
// expected results are queued when a run is launched and a monitor compares
// each word the DUT hands downstream.
`timescale 1ns/1ps
module tb_stencil_2d_invoker;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run_start = 1'b0;
    logic [15:0] run_count = '0;
    logic        run_busy;
    logic        run_done;
    logic        comp_start;
    logic        comp_busy = 1'b0;
    logic        comp_done;
    logic        comp_stall;
    logic [31:0] comp_returndata;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_data;
    logic [31:0] checksum;
    logic [31:0] cycles;
    logic        err_unexpected;

    // component model state
    logic        model_done = 1'b0;
    logic [31:0] model_data = '0;
    logic        man_done = 1'b0;
    logic [31:0] man_data = '0;
    bit          model_en = 1'b0;
    int          lat = 5;
    int          clr_gen = 0;
    int          last_gen = 0;
    int          data_idx = 0;
    bit          acc_pending = 1'b0;
    logic [31:0] data_tab [8];
    int          due_q[$];

    int          cyc = 0;
    int          call_cnt = 0;
    int          ret_cnt = 0;
    int          done_cnt = 0;
    int          start_hi = 0;

    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    assign comp_done       = model_done | man_done;
    assign comp_returndata = man_done ? man_data : model_data;

    stencil_2d_invoker #(.MAX_OUT(4), .FIFO_DEPTH(4)) dut (
        .clock(clock),
        .reset(reset),
        .run_start(run_start),
        .run_count(run_count),
        .run_busy(run_busy),
        .run_done(run_done),
        .comp_start(comp_start),
        .comp_busy(comp_busy),
        .comp_done(comp_done),
        .comp_stall(comp_stall),
        .comp_returndata(comp_returndata),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .checksum(checksum),
        .cycles(cycles),
        .err_unexpected(err_unexpected)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // stencil_2d model: answers each accepted call lat cycles later, holds
    // comp_done until the return is taken; also counts events for the checks
    task automatic model_loop();
        forever begin
            @(negedge clock);
            if (clr_gen != last_gen) begin
                last_gen    = clr_gen;
                due_q.delete();
                data_idx    = 0;
                acc_pending = 1'b0;
            end
            if (acc_pending) begin
                void'(due_q.pop_front());
                data_idx++;
                ret_cnt++;
            end
            if (comp_start && !comp_busy) begin
                call_cnt++;
                due_q.push_back(cyc + lat);
            end
            if (model_en && due_q.size() != 0 && due_q[0] <= cyc) begin
                model_done = 1'b1;
                model_data = data_tab[data_idx % 8];
            end else begin
                model_done = 1'b0;
            end
            acc_pending = model_done && !comp_stall && !reset;
            if (run_done) done_cnt++;
            if (comp_start) start_hi++;
        end
    endtask

    // scoreboard monitor: compares every word accepted downstream
    task automatic monitor_loop();
        forever begin
            @(negedge clock);
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got 0x%08h, expected no result", res_data);
                end else begin
                    check("sb_data", res_data, exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic drive_tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample_tick();
        @(negedge clock);
        #1;
    endtask

    task automatic start_run(input logic [15:0] n);
        drive_tick();
        run_start = 1'b1;
        run_count = n;
        drive_tick();
        run_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            sample_tick();
            if (run_done) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic do_reset(input int n);
        drive_tick();
        reset = 1'b1;
        repeat (n) drive_tick();
        reset = 1'b0;
        clr_gen++;
    endtask

    initial begin
        int c0;
        int d0;
        int s0;
        int r0;
        bit seen;

        fork
            model_loop();
            monitor_loop();
        join_none

        // reset state
        repeat (2) drive_tick();
        sample_tick();
        check("rst_outputs", {27'd0, run_busy, run_done, comp_start, comp_stall, res_valid}, 32'd0);
        check("rst_res_data", res_data, 32'd0);
        drive_tick();
        reset = 1'b0;
        sample_tick();
        check("rst_checksum", checksum, 32'd0);
        check("rst_cycles", cycles, 32'd0);
        check("rst_err", 32'(err_unexpected), 32'd0);
        check("rst_busy", 32'(run_busy), 32'd0);

        // three calls, 5-cycle component latency, free-flowing consumer
        clr_gen++;
        model_en = 1'b1;
        lat = 5;
        data_tab[0] = 32'h11; data_tab[1] = 32'h22; data_tab[2] = 32'h44;
        exp_q.push_back(32'h11); exp_q.push_back(32'h22); exp_q.push_back(32'h44);
        d0 = done_cnt;
        start_run(16'd3);
        sample_tick();
        check("t3_first_start", 32'(comp_start), 32'd1);
        check("t3_busy", 32'(run_busy), 32'd1);
        // a second request mid-run must be ignored
        drive_tick();
        run_start = 1'b1;
        run_count = 16'd9;
        drive_tick();
        run_start = 1'b0;
        wait_done("t3_done_timeout", 200);
        check("t3_checksum", checksum, 32'h77);
        check("t3_calls", 32'(call_cnt), 32'd3);
        repeat (3) sample_tick();
        check("t3_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t3_err", 32'(err_unexpected), 32'd0);
        check("t3_cycles_nonzero", 32'(cycles != 0), 32'd1);
        check("t3_left", 32'(exp_q.size()), 32'd0);

        // empty run
        clr_gen++;
        d0 = done_cnt;
        s0 = start_hi;
        start_run(16'd0);
        wait_done("t0_done_timeout", 3);
        repeat (3) sample_tick();
        check("t0_no_start", 32'(start_hi - s0), 32'd0);
        check("t0_cycles", cycles, 32'd0);
        check("t0_done_pulses", 32'(done_cnt - d0), 32'd1);

        // component never returns: in-flight limit
        clr_gen++;
        model_en = 1'b0;
        c0 = call_cnt;
        start_run(16'd8);
        repeat (30) sample_tick();
        check("t8_calls", 32'(call_cnt - c0), 32'd4);
        check("t8_start_low", 32'(comp_start), 32'd0);
        check("t8_busy", 32'(run_busy), 32'd1);
        do_reset(2);

        // consumer blocked: FIFO fills and stalls the component
        model_en = 1'b1;
        lat = 2;
        for (int i = 0; i < 6; i++) begin
            data_tab[i] = 32'(i + 1);
            exp_q.push_back(32'(i + 1));
        end
        res_ready = 1'b0;
        r0 = ret_cnt;
        start_run(16'd6);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            sample_tick();
            if (comp_stall) begin
                seen = 1'b1;
                break;
            end
        end
        check("t6_stall_timeout", 32'(seen), 32'd1);
        check("t6_returns_at_stall", 32'(ret_cnt - r0), 32'd4);
        check("t6_head", res_data, 32'd1);
        repeat (5) sample_tick();
        check("t6_done_held", 32'(comp_done), 32'd1);
        check("t6_still_stall", 32'(comp_stall), 32'd1);
        check("t6_returns_held", 32'(ret_cnt - r0), 32'd4);
        drive_tick();
        res_ready = 1'b1;
        wait_done("t6_done_timeout", 100);
        check("t6_checksum", checksum, 32'h7);
        check("t6_left", 32'(exp_q.size()), 32'd0);
        repeat (2) sample_tick();

        // busy component on the first call
        clr_gen++;
        lat = 2;
        data_tab[0] = 32'h5A;
        exp_q.push_back(32'h5A);
        comp_busy = 1'b1;
        c0 = call_cnt;
        s0 = start_hi;
        start_run(16'd1);
        for (int i = 0; i < 3; i++) begin
            sample_tick();
            check("tb_start_held", 32'(comp_start), 32'd1);
            check("tb_no_issue", 32'(call_cnt - c0), 32'd0);
            drive_tick();
        end
        comp_busy = 1'b0;
        sample_tick();
        check("tb_start_4th", 32'(comp_start), 32'd1);
        check("tb_issue", 32'(call_cnt - c0), 32'd1);
        drive_tick();
        sample_tick();
        check("tb_start_drop", 32'(comp_start), 32'd0);
        check("tb_start_cycles", 32'(start_hi - s0), 32'd4);
        wait_done("tb_done_timeout", 50);
        check("tb_checksum", checksum, 32'h5A);

        // reset with calls in flight, then a late return
        repeat (2) sample_tick();
        clr_gen++;
        model_en = 1'b0;
        c0 = call_cnt;
        start_run(16'd2);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sample_tick();
            if (call_cnt - c0 == 2) begin
                seen = 1'b1;
                break;
            end
        end
        check("tr_calls_timeout", 32'(seen), 32'd1);
        d0 = done_cnt;
        drive_tick();
        reset = 1'b1;
        sample_tick();
        check("tr_outputs", {27'd0, run_busy, run_done, comp_start, comp_stall, res_valid}, 32'd0);
        check("tr_res_data", res_data, 32'd0);
        drive_tick();
        drive_tick();
        reset = 1'b0;
        clr_gen++;
        man_done = 1'b1;
        man_data = 32'hDEAD;
        drive_tick();
        man_done = 1'b0;
        sample_tick();
        check("tr_err", 32'(err_unexpected), 32'd1);
        check("tr_checksum", checksum, 32'd0);
        check("tr_no_valid", 32'(res_valid), 32'd0);
        repeat (5) sample_tick();
        check("tr_no_done", 32'(done_cnt - d0), 32'd0);
        check("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
